// File: rtl/optical_tx_framer.sv
// optical_tx_framer: multi-lane transmit frame builder for the GTP optical links.
// After all lanes report GTP ready it sends BOND_COUNT channel-bonding frames
// (one per BOND_GAP cycles), then MARKER_FRAMES latency-marker frames, then
// continuous payload frames carrying either per-lane PRBS-31 data or user data.
// Optional feature macro: OPTICAL_TX_ERR_INJ_EN adds the inj_err port, which
// inverts bit 16 of lane 0 for one PRBS frame.
module optical_tx_framer #(
  parameter int NCH           = 2,
  parameter int BOND_GAP      = 32,
  parameter int BOND_COUNT    = 255,
  parameter int MARKER_FRAMES = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NCH-1:0]      gtp_reset_done,
`ifdef OPTICAL_TX_ERR_INJ_EN
  input  logic                inj_err,
`endif
  input  logic                mode,
  input  logic [48*NCH-1:0]   user_data,
  input  logic                user_valid,
  output logic                user_ready,
  output logic [64*NCH-1:0]   tx_data,
  output logic [8*NCH-1:0]    tx_iskchar,
  output logic [1:0]          tx_state,
  output logic                bonding_done,
  output logic                frame_sync
);

  localparam int GW = $clog2(BOND_GAP + 1);

  localparam logic [63:0] BOND_WORD   = 64'h1CFEFBDC_00000000;
  localparam logic [63:0] MARKER_WORD = 64'hFCFCFCFC_FCFCFCFC;
  localparam logic [63:0] IDLE_WORD   = 64'h0000_0000_0000_3CBC;
  localparam logic [15:0] DATA_TRAIL  = 16'hBC50;
  localparam logic [30:0] SEED_BASE   = 31'h7FFFFFFF;

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_BOND = 2'd1,
    S_MARK = 2'd2,
    S_DATA = 2'd3
  } state_t;

  state_t                 state;
  logic [GW-1:0]          gap_cnt;
  logic [7:0]             bond_cnt;
  logic [3:0]             mark_cnt;
  logic [NCH-1:0][30:0]   prbs_q;
  logic [NCH-1:0][30:0]   prbs_nxt;
  logic [NCH-1:0][47:0]   prbs_word;

  // Runs the x^31+x^28+1 LFSR for 48 steps; the first generated bit lands in
  // the MSB of the word. Returns {advanced state, 48-bit word}.
  function automatic logic [78:0] prbs_step48(input logic [30:0] seed);
    logic [30:0] s;
    logic [47:0] w;
    logic        nb;
    s = seed;
    w = '0;
    for (int i = 0; i < 48; i++) begin
      nb = s[30] ^ s[27];
      w  = {w[46:0], nb};
      s  = {s[29:0], nb};
    end
    return {s, w};
  endfunction

  for (genvar g = 0; g < NCH; g++) begin : g_prbs
    assign {prbs_nxt[g], prbs_word[g]} = prbs_step48(prbs_q[g]);
  end

  assign tx_state   = state;
  assign user_ready = (state == S_DATA) && mode;

  // Startup sequencer and output frame register; any lane losing GTP ready
  // restarts the whole sequence from WAIT with reseeded PRBS generators.
  always_ff @(posedge clock) begin
    frame_sync <= 1'b0;
    if (reset || !(&gtp_reset_done)) begin
      state        <= S_WAIT;
      gap_cnt      <= '0;
      bond_cnt     <= '0;
      mark_cnt     <= '0;
      tx_data      <= '0;
      tx_iskchar   <= '0;
      bonding_done <= 1'b0;
      for (int c = 0; c < NCH; c++) prbs_q[c] <= SEED_BASE ^ 31'(c);
    end else begin
      case (state)
        S_WAIT: begin
          state        <= S_BOND;
          gap_cnt      <= '0;
          bond_cnt     <= '0;
          mark_cnt     <= '0;
          tx_data      <= '0;
          tx_iskchar   <= '0;
          bonding_done <= 1'b0;
          for (int c = 0; c < NCH; c++) prbs_q[c] <= SEED_BASE ^ 31'(c);
        end
        S_BOND: begin
          for (int c = 0; c < NCH; c++) prbs_q[c] <= SEED_BASE ^ 31'(c);
          if (gap_cnt == GW'(BOND_GAP - 1)) begin
            gap_cnt    <= '0;
            bond_cnt   <= bond_cnt + 8'd1;
            tx_data    <= {NCH{BOND_WORD}};
            tx_iskchar <= {NCH{8'h0F}};
            if (bond_cnt == 8'(BOND_COUNT - 1)) begin
              state        <= S_MARK;
              bonding_done <= 1'b1;
              mark_cnt     <= '0;
            end
          end else begin
            gap_cnt    <= gap_cnt + GW'(1);
            tx_data    <= '0;
            tx_iskchar <= '0;
          end
        end
        S_MARK: begin
          for (int c = 0; c < NCH; c++) prbs_q[c] <= SEED_BASE ^ 31'(c);
          tx_data    <= {NCH{MARKER_WORD}};
          tx_iskchar <= {NCH{8'hFF}};
          frame_sync <= (mark_cnt == 4'd0);
          mark_cnt   <= mark_cnt + 4'd1;
          if (mark_cnt == 4'(MARKER_FRAMES - 1)) state <= S_DATA;
        end
        S_DATA: begin
          tx_iskchar <= {NCH{8'h01}};
          for (int c = 0; c < NCH; c++) begin
            if (!mode) begin
              tx_data[64*c +: 64] <= {prbs_word[c], DATA_TRAIL};
              prbs_q[c]           <= prbs_nxt[c];
            end else if (user_valid) begin
              tx_data[64*c +: 64] <= {user_data[48*c +: 48], DATA_TRAIL};
            end else begin
              tx_data[64*c +: 64] <= IDLE_WORD;
            end
          end
`ifdef OPTICAL_TX_ERR_INJ_EN
          if (!mode && inj_err) tx_data[16] <= ~prbs_word[0][0];
`endif
        end
        default: state <= S_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_optical_tx_framer.sv
// Scoreboard bench for optical_tx_framer (NCH=2, BOND_GAP=4, BOND_COUNT=3,
// MARKER_FRAMES=1). Stimulus pushes the expected frame for each cycle into a
// queue; a separate monitor pops and compares one entry per output frame.
// Define OPTICAL_TX_ERR_INJ_EN to also exercise the error-injection port.
module tb_optical_tx_framer;

  localparam int NCH = 2;
  localparam logic [63:0] BOND_W = 64'h1CFEFBDC_00000000;
  localparam logic [63:0] MARK_W = 64'hFCFCFCFC_FCFCFCFC;
  localparam logic [63:0] IDLE_W = 64'h0000_0000_0000_3CBC;

  logic              clock;
  logic              reset;
  logic [NCH-1:0]    gtp_reset_done;
  logic              mode;
  logic [48*NCH-1:0] user_data;
  logic              user_valid;
  logic              user_ready;
  logic [64*NCH-1:0] tx_data;
  logic [8*NCH-1:0]  tx_iskchar;
  logic [1:0]        tx_state;
  logic              bonding_done;
  logic              frame_sync;
`ifdef OPTICAL_TX_ERR_INJ_EN
  logic              inj_err;
`endif

  typedef struct packed {
    logic [63:0] d0;
    logic [63:0] d1;
    logic [7:0]  k;
    logic [1:0]  st;
    logic        sync;
    logic        bd;
    logic        ur;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  optical_tx_framer #(
    .NCH(NCH), .BOND_GAP(4), .BOND_COUNT(3), .MARKER_FRAMES(1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .gtp_reset_done(gtp_reset_done),
`ifdef OPTICAL_TX_ERR_INJ_EN
    .inj_err(inj_err),
`endif
    .mode(mode),
    .user_data(user_data),
    .user_valid(user_valid),
    .user_ready(user_ready),
    .tx_data(tx_data),
    .tx_iskchar(tx_iskchar),
    .tx_state(tx_state),
    .bonding_done(bonding_done),
    .frame_sync(frame_sync)
  );

  // Free-running 100 MHz-style bench clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Independent PRBS-31 reference written as a bit sequence:
  // b[0..30] are the seed bits oldest-first, b[n] = b[n-31] ^ b[n-28].
  function automatic logic [47:0] modelWord(input int lane, input int k);
    bit          seq [0:2047];
    logic [30:0] seed;
    logic [47:0] w;
    seed = 31'h7FFFFFFF ^ 31'(lane);
    for (int i = 0; i < 31; i++) seq[i] = seed[30-i];
    for (int n = 31; n < 31 + 48*(k+1); n++) seq[n] = seq[n-31] ^ seq[n-28];
    w = '0;
    for (int j = 0; j < 48; j++) w = {w[46:0], seq[31 + 48*k + j]};
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Drives one cycle of inputs and records the frame expected after the next edge
  task automatic applyStimulus(input logic rst, input logic [1:0] gtp, input logic md,
                               input logic vld, input logic [95:0] ud,
                               input logic [63:0] e0, input logic [63:0] e1,
                               input logic [7:0] ek, input logic [1:0] est,
                               input logic esync);
    exp_t e;
    reset          = rst;
    gtp_reset_done = gtp;
    mode           = md;
    user_valid     = vld;
    user_data      = ud;
    e.d0   = e0;
    e.d1   = e1;
    e.k    = ek;
    e.st   = est;
    e.sync = esync;
    e.bd   = (est == 2'd2) || (est == 2'd3);
    e.ur   = (est == 2'd3) && md;
    exp_q.push_back(e);
    @(negedge clock);
  endtask

  task automatic runStartup();
    applyStimulus(1'b0, 2'b11, 1'b0, 1'b0, '0, '0, '0, 8'h00, 2'd1, 1'b0);
    for (int b = 0; b < 3; b++) begin
      for (int z = 0; z < 3; z++)
        applyStimulus(1'b0, 2'b11, 1'b0, 1'b0, '0, '0, '0, 8'h00, 2'd1, 1'b0);
      applyStimulus(1'b0, 2'b11, 1'b0, 1'b0, '0, BOND_W, BOND_W, 8'h0F,
                    (b == 2) ? 2'd2 : 2'd1, 1'b0);
    end
    applyStimulus(1'b0, 2'b11, 1'b0, 1'b0, '0, MARK_W, MARK_W, 8'hFF, 2'd3, 1'b1);
  endtask

  task automatic prbsFrame(input int idx);
    applyStimulus(1'b0, 2'b11, 1'b0, 1'b0, '0,
                  {modelWord(0, idx), 16'hBC50}, {modelWord(1, idx), 16'hBC50},
                  8'h01, 2'd3, 1'b0);
  endtask

  task automatic userFrame(input logic vld, input logic [95:0] ud);
    logic [63:0] e0, e1;
    e0 = vld ? {ud[47:0], 16'hBC50}  : IDLE_W;
    e1 = vld ? {ud[95:48], 16'hBC50} : IDLE_W;
    applyStimulus(1'b0, 2'b11, 1'b1, vld, ud, e0, e1, 8'h01, 2'd3, 1'b0);
  endtask

  // Monitor: one frame per clock, compared just after the active edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("lane0_data",   tx_data[63:0],       e.d0);
        checkOutput("lane1_data",   tx_data[127:64],     e.d1);
        checkOutput("iskchar",      64'(tx_iskchar),     64'({e.k, e.k}));
        checkOutput("tx_state",     64'(tx_state),       64'(e.st));
        checkOutput("frame_sync",   64'(frame_sync),     64'(e.sync));
        checkOutput("bonding_done", 64'(bonding_done),   64'(e.bd));
        checkOutput("user_ready",   64'(user_ready),     64'(e.ur));
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence
  initial begin
    logic [95:0] ud_tab [6];
    logic        vld_tab [6];
`ifdef OPTICAL_TX_ERR_INJ_EN
    inj_err = 1'b0;
`endif
    ud_tab[0] = 96'h1111_2222_3333_4444_5555_6666;
    ud_tab[1] = 96'hDEAD_BEEF_0000_CAFE_F00D_1234;
    ud_tab[2] = 96'hA5A5_5A5A_0F0F_F0F0_1357_9BDF;
    ud_tab[3] = 96'hFFFF_FFFF_FFFF_0000_0000_0001;
    ud_tab[4] = 96'h0123_4567_89AB_CDEF_FEDC_BA98;
    ud_tab[5] = 96'h8000_0000_0001_7FFF_FFFF_FFFE;
    vld_tab[0] = 1'b1; vld_tab[1] = 1'b0; vld_tab[2] = 1'b1;
    vld_tab[3] = 1'b1; vld_tab[4] = 1'b0; vld_tab[5] = 1'b1;

    applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, '0, '0, '0, 8'h00, 2'd0, 1'b0);
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, '0, '0, '0, 8'h00, 2'd0, 1'b0);

    runStartup();

    for (int i = 0; i < 5; i++) prbsFrame(i);
    for (int i = 0; i < 6; i++) userFrame(vld_tab[i], ud_tab[i]);
    for (int i = 5; i < 8; i++) prbsFrame(i);

`ifdef OPTICAL_TX_ERR_INJ_EN
    inj_err = 1'b1;
    applyStimulus(1'b0, 2'b11, 1'b0, 1'b0, '0,
                  {modelWord(0, 8), 16'hBC50} ^ 64'h0000_0000_0001_0000,
                  {modelWord(1, 8), 16'hBC50}, 8'h01, 2'd3, 1'b0);
    inj_err = 1'b0;
    prbsFrame(9);
`endif

    applyStimulus(1'b0, 2'b01, 1'b0, 1'b0, '0, '0, '0, 8'h00, 2'd0, 1'b0);
    applyStimulus(1'b0, 2'b01, 1'b0, 1'b0, '0, '0, '0, 8'h00, 2'd0, 1'b0);

    runStartup();
    for (int i = 0; i < 3; i++) prbsFrame(i);

    applyStimulus(1'b1, 2'b11, 1'b1, 1'b1, ud_tab[1], '0, '0, 8'h00, 2'd0, 1'b0);
    applyStimulus(1'b0, 2'b11, 1'b1, 1'b1, ud_tab[2], '0, '0, 8'h00, 2'd1, 1'b0);

    repeat (2) @(posedge clock);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/optical_tx_framer.md
# optical_tx_framer

Parametrised multi-lane transmit frame builder for the GTP optical links. It sits in the 40 MHz logic domain ahead of the per-lane clock-crossing FIFOs. At startup it sends a configurable run of channel-bonding frames, then a latency marker frame, then continuous payload frames. Payload is either per-lane PRBS-31 test data or user data accepted through a valid/ready handshake.

## Interface
Parameters:
- NCH, 2: number of lanes (1–8).
- BOND_GAP, 32: frame period of bonding frames (4–256). One bonding frame per BOND_GAP cycles.
- BOND_COUNT, 255: number of bonding frames sent before the marker (1–255).
- MARKER_FRAMES, 1: number of consecutive marker frames (1–15).

Ports:
- clock, input, 1: 40 MHz logic clock; the only clock.
- reset, input, 1: synchronous, active-high.
- gtp_reset_done, input, NCH: per-lane GTP ready. All bits must be high to leave WAIT.
- mode, input, 1: payload source in DATA. 0 = PRBS, 1 = user.
- user_data, input, 48·NCH: lane c payload is bits [48c+47:48c].
- user_valid, input, 1: user_data is valid.
- user_ready, output, 1: the framer accepts user_data this cycle.
- tx_data, output, 64·NCH: lane c frame is bits [64c+63:64c].
- tx_iskchar, output, 8·NCH: K-flags for lane c are bits [8c+7:8c]. Bit i flags byte i.
- tx_state, output, 2: 0 WAIT, 1 BOND, 2 MARK, 3 DATA.
- bonding_done, output, 1: high in MARK and DATA.
- frame_sync, output, 1: one-cycle pulse, coincident with the first marker frame on tx_data.

## Operation
- FSM states are WAIT, BOND, MARK and DATA.
- From any state, reset or !(&gtp_reset_done) forces WAIT on the next edge and clears all counters.
- WAIT → BOND when &gtp_reset_done is high.
- BOND:
  - gap_cnt counts 0..BOND_GAP-1 and wraps.
  - At gap_cnt==BOND_GAP-1, emit a bonding frame: 64'h1CFEFBDC_00000000 with iskchar 8'h0F (K-flags on the low four bytes, as defined). Then bond_cnt increments.
  - Every other BOND cycle emits a zero frame: tx_data 0, iskchar 0.
  - When the bonding frame that brings bond_cnt to BOND_COUNT is emitted, go to MARK.
- MARK:
  - Emit 64'hFCFCFCFC_FCFCFCFC with iskchar 8'hFF on all lanes for MARKER_FRAMES cycles, then go to DATA.
  - frame_sync pulses on the first marker frame only.
- DATA, PRBS mode (mode=0):
  - Lane c frame = {prbs_c[47:0], 16'hBC50}, iskchar 8'h01.
  - Each lane has its own PRBS-31 generator (x^31+x^28+1). It advances 48 bits per frame; the MSB of each 48-bit word is the oldest bit.
  - Lane c seed is 31'h7FFFFFFF ^ c. Seeds are loaded in every non-DATA cycle.
- DATA, user mode (mode=1):
  - user_ready = 1.
  - On user_valid: lane c frame = {user_data lane c, 16'hBC50}, iskchar 8'h01.
  - Without user_valid: idle frame 64'h0000_0000_0000_3CBC, iskchar 8'h01.
  - The PRBS generators hold their value while mode=1.
- user_ready is 0 outside DATA and whenever mode=0. A transfer occurs only when user_valid && user_ready.
- A mode change takes effect on the frame produced from that cycle's inputs. The PRBS sequence resumes where it stopped.

## Timing
- All outputs are registered. A frame reflects the state and inputs sampled on the previous edge: 1-cycle latency from user_data to tx_data.
- user_ready is combinational from state and mode.
- Reset values: tx_data 0, tx_iskchar 0, tx_state 0, bonding_done 0, frame_sync 0, user_ready 0, gap_cnt 0, bond_cnt 0.
- First bonding frame appears on tx_data BOND_GAP+1 cycles after the first cycle with &gtp_reset_done high.
- A gtp_reset_done bit dropping mid-BOND, mid-MARK or mid-DATA gives tx_data 0 on the next frame. The full startup sequence restarts with PRBS reseeded.
- Simultaneous reset and valid user data: reset wins and the data is dropped.

## Configuration
- OPTICAL_TX_ERR_INJ_EN defined:
  - Adds input port inj_err (1 bit).
  - When inj_err is high in DATA with mode=0, bit 16 of lane 0's next frame is inverted for that single frame.
  - The PRBS state is unaffected.
- OPTICAL_TX_ERR_INJ_EN undefined: no inj_err port and no inversion logic.

## Test plan
- Startup, NCH=2, BOND_GAP=4, BOND_COUNT=3:
  - Release reset with gtp_reset_done=2'b11 → exactly 3 frames of 1CFEFBDC_00000000/0F, spaced 4 cycles, with zeros between.
  - Then 1 marker frame FCFC…/FF with frame_sync=1.
  - Then DATA frames whose low 16 bits are BC50.
- PRBS: in DATA with mode=0 → each lane's 48-bit payload stream matches a PRBS-31 model seeded 7FFFFFFF^c. Lanes 0 and 1 differ.
- User handshake: mode=1, user_valid toggling → valid cycles give {user_data,BC50}; invalid cycles give 0…3CBC/01. user_ready=1 throughout DATA.
- Lane drop: clear gtp_reset_done[1] mid-DATA → next frame 0 and tx_state=0. Reassert → full bonding sequence repeats and the PRBS restarts from the seed.
- Mode switch: PRBS for 5 frames, user for 3, PRBS again → the 6th PRBS word equals the model's 6th word.
- With OPTICAL_TX_ERR_INJ_EN: pulse inj_err once in PRBS DATA → exactly one lane-0 frame has bit 16 flipped; the following frame matches the model.
